// File: rtl/fwd_lkp_arb_if.sv
// Request/result and lookup-port bundle between the ingress requesters,
// the lookup arbiter and the forwarding lookup block.
interface fwd_lkp_arb_if #(
  parameter int PORT_NUM = 4,
  parameter int DW       = 16
);
  logic [PORT_NUM-1:0]   lkp_req;
  logic [PORT_NUM*8-1:0] lkp_addr;
  logic [PORT_NUM-1:0]   lkp_ack;
  logic [PORT_NUM-1:0]   lkp_vld;
  logic [DW-1:0]         lkp_data;
  logic                  fwd_rden;
  logic [7:0]            fwd_addr;
  logic [DW-1:0]         fwd_data;

  // Arbiter side: takes requests and lookup results, drives acks, results
  // and the lookup read port.
  modport master (
    input  lkp_req, lkp_addr, fwd_data,
    output lkp_ack, lkp_vld, lkp_data, fwd_rden, fwd_addr
  );

  // Requester / lookup-block side.
  modport slave (
    output lkp_req, lkp_addr, fwd_data,
    input  lkp_ack, lkp_vld, lkp_data, fwd_rden, fwd_addr
  );
endinterface

// File: rtl/fwd_lkp_arb.sv
// Round-robin arbiter sharing one forwarding-lookup read port among
// PORT_NUM requesters. One grant per cycle, fixed 3-cycle ack-to-result
// latency, no back-pressure, plus a saturating issued-lookup counter.
module fwd_lkp_arb #(
  parameter int PORT_NUM = 4,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arb_en,
  fwd_lkp_arb_if.master bus,
  output logic [15:0]   lkp_cnt,
  output logic          busy
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  // (base + ofs) mod PORT_NUM for ofs < PORT_NUM.
  function automatic logic [PW-1:0] port_wrap(input logic [PW-1:0] base,
                                              input int unsigned   ofs);
    int unsigned sum;
    sum = {{(32-PW){1'b0}}, base} + ofs;
    if (sum >= unsigned'(PORT_NUM)) sum = sum - unsigned'(PORT_NUM);
    return sum[PW-1:0];
  endfunction

  function automatic logic [PORT_NUM-1:0] onehot(input logic [PW-1:0] idx);
    logic [PORT_NUM-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;

  logic                gnt_vld;
  logic [PW-1:0]       gnt_idx;
  logic [7:0]          gnt_addr;
  logic [7:0]          addr_arr [PORT_NUM];

  logic                vld_p1_q, vld_p1_d;
  logic [PW-1:0]       port_p1_q, port_p1_d;
  logic [7:0]          addr_p1_q, addr_p1_d;

  logic                vld_p2_q, vld_p2_d;
  logic [PW-1:0]       port_p2_q, port_p2_d;

  logic [PORT_NUM-1:0] vld_p3_q, vld_p3_d;
  logic [DW-1:0]       data_p3_q, data_p3_d;

  logic [15:0]         cnt_q, cnt_d;

  // Unpack the flat per-port address bus.
  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      addr_arr[i] = bus.lkp_addr[i*8 +: 8];
    end
  end

  // Stage p0: pick the first requester at or after rr_ptr. Nothing is
  // granted while disabled or while reset is asserted.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_addr = '0;
    if (rst_n && arb_en) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (!gnt_vld && bus.lkp_req[port_wrap(rr_ptr_q, unsigned'(i))]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = port_wrap(rr_ptr_q, unsigned'(i));
          gnt_addr = addr_arr[port_wrap(rr_ptr_q, unsigned'(i))];
        end
      end
    end
  end

  assign bus.lkp_ack = gnt_vld ? onehot(gnt_idx) : '0;

  // Next state for the pointer, the three pipeline stages and the counter.
  // The read address and the result hold when their stage is empty.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = port_wrap(gnt_idx, 1);

    // p0 -> p1: issue the read to the lookup block
    vld_p1_d  = gnt_vld;
    port_p1_d = gnt_vld ? gnt_idx  : port_p1_q;
    addr_p1_d = gnt_vld ? gnt_addr : addr_p1_q;

    // p1 -> p2: lookup block returns data during p2
    vld_p2_d  = vld_p1_q;
    port_p2_d = port_p1_q;

    // p2 -> p3: capture lookup data and steer the valid to its owner
    vld_p3_d  = vld_p2_q ? onehot(port_p2_q) : '0;
    data_p3_d = vld_p2_q ? bus.fwd_data : data_p3_q;

    cnt_d     = gnt_vld ? sat_inc(cnt_q) : cnt_q;
  end

  // State registers; reset discards every in-flight lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      vld_p1_q  <= 1'b0;
      port_p1_q <= '0;
      addr_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      port_p2_q <= '0;
      vld_p3_q  <= '0;
      data_p3_q <= '0;
      cnt_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      vld_p1_q  <= vld_p1_d;
      port_p1_q <= port_p1_d;
      addr_p1_q <= addr_p1_d;
      vld_p2_q  <= vld_p2_d;
      port_p2_q <= port_p2_d;
      vld_p3_q  <= vld_p3_d;
      data_p3_q <= data_p3_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.fwd_rden = vld_p1_q;
  assign bus.fwd_addr = addr_p1_q;
  assign bus.lkp_vld  = vld_p3_q;
  assign bus.lkp_data = data_p3_q;
  assign lkp_cnt      = cnt_q;
  assign busy         = vld_p1_q | vld_p2_q | (|vld_p3_q);

endmodule

// File: doc/fwd_lkp_arb.md
# fwd_lkp_arb

Round-robin arbiter that shares the single forwarding-lookup read port (`fwd_rden`/`fwd_addr`/`fwd_data`) of the forwarding lookup block among `PORT_NUM` ingress requesters. It sits between the per-port ingress parsers and the forwarding lookup block, and issues at most one lookup per clock. It returns each result to the requester that issued it, with fixed latency. It also keeps a saturating count of issued lookups for host diagnostics.

## Interface
- `PORT_NUM`, 4: number of requesters (2..8).
- `DW`, 12+`CHANNEL_NUM`: lookup result width; equals the `fwd_data` width.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `arb_en` input 1: when 1, new grants are allowed; when 0, no new grants are made and in-flight lookups still complete.
- `lkp_req` input PORT_NUM: per-port lookup request; held high until acked.
- `lkp_addr` input PORT_NUM*8: per-port lookup address; port i uses bits [i*8+7:i*8].
- `lkp_ack` output PORT_NUM: one-hot, combinational; request accepted this cycle.
- `lkp_vld` output PORT_NUM: one-hot, registered; result valid for that port.
- `lkp_data` output DW: registered result, shared by all ports; qualified by `lkp_vld`.
- `fwd_rden` output 1: registered read enable to the lookup block.
- `fwd_addr` output 8: registered read address to the lookup block.
- `fwd_data` input DW: lookup result; valid exactly one cycle after `fwd_rden`.
- `lkp_cnt` output 16: registered count of issued lookups; saturates at 0xFFFF.
- `busy` output 1: 1 while any lookup is in stages S1..S3.

## Operation
- Round-robin pointer `rr_ptr` (0..PORT_NUM-1) names the highest-priority port.
- Each cycle with `arb_en`=1, the first port with `lkp_req`=1, searching from `rr_ptr` upward modulo PORT_NUM, is granted.
  - `lkp_ack[g]`=1 in the same cycle.
  - `rr_ptr` <= (g+1) mod PORT_NUM.
- With no grant, `rr_ptr` holds.
- Pipeline, one slot per stage; every stage carries a valid bit and the port index.
  - S1: `fwd_rden`=1 and `fwd_addr`=addr of g, registered from the grant cycle.
  - S2: `fwd_data` is sampled from the lookup block.
  - S3: `lkp_data` <= the S2 data and `lkp_vld[port]`=1 for exactly one cycle.
- `lkp_ack` is never asserted for a port whose `lkp_req`=0, and never while `arb_en`=0.
- A requester may present a new address in the cycle after its ack. A port requesting continuously alone therefore gets one lookup per cycle.
- `lkp_cnt` increments once per grant and stops at 0xFFFF. It is cleared only by reset.
- The pipeline never stalls; results cannot be back-pressured. Requesters must accept `lkp_vld` when it arrives.
- Host write/read access to the table is handled inside the lookup block. This arbiter neither sees nor blocks host access.

## Timing
- Grant at cycle T leads to:
  - `lkp_ack` at T (combinational);
  - `fwd_rden`/`fwd_addr` at T+1;
  - `fwd_data` valid at T+2;
  - `lkp_vld`/`lkp_data` at T+3.
- Fixed latency from ack to result: 3 cycles.
- Throughput: 1 lookup per cycle in aggregate. With all ports requesting, each port gets 1 lookup per PORT_NUM cycles.
- `fwd_rden` is 0 in any cycle whose S1 slot is empty. `fwd_addr` holds its last value when `fwd_rden`=0.
- `arb_en` falling at T: no ack at T. Lookups granted before T still produce `lkp_vld` at their scheduled cycles. `busy` drops 3 cycles after the last grant.
- `arb_en` rising: arbitration resumes from the held `rr_ptr`.
- Reset values (asynchronous, while `rst_n`=0):
  - `rr_ptr`=0;
  - all stage valid bits 0;
  - `fwd_rden`=0, `fwd_addr`=0;
  - `lkp_vld`=0, `lkp_data`=0;
  - `lkp_cnt`=0, `busy`=0.
  - `lkp_ack`=0 while in reset.
- Reset mid-operation: all in-flight lookups are discarded and no `lkp_vld` is produced for them.
- The same requester may be acked again while its earlier results are still in flight. Results return in issue order.

## Test plan
- Single request: port 0, addr 0x15, table[0x15]=0x3A5 -> `lkp_ack`=0001 at T, `fwd_rden`=1 with `fwd_addr`=0x15 at T+1, `lkp_vld`=0001 with `lkp_data`=0x3A5 at T+3, `lkp_cnt`=1.
- All four ports requesting continuously, addrs 0x10..0x13 -> acks rotate 0,1,2,3,0,... one per cycle; `lkp_vld` rotates identically 3 cycles later, each with its port's table data.
- Fairness after idle: with `rr_ptr`=2, ports 0 and 3 request together -> port 3 acked first, port 0 next cycle, then `rr_ptr`=1.
- `arb_en` dropped for 5 cycles while ports 1 and 2 request -> no acks and `fwd_rden`=0 during that window; 2 results already in flight still return; `busy` falls 3 cycles after the last grant; grants resume from the held pointer.
- Assert `rst_n`=0 asynchronously with 3 lookups in flight -> all outputs go to 0 immediately and no `lkp_vld` appears after release; the first post-reset grant goes to the lowest requesting port index.
- Preload `lkp_cnt` to 0xFFFE via 3 forced grants past the limit -> count reads 0xFFFF and does not wrap.
